lsu_dispatch: RTL and testbench
===============================

LSU_DISPATCH -- requirements
Module: lsu_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 8 (power of two, 2..32), meaning the op-queue entry count.
REQ-002 clock_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 nReset_i  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 enqValid_i  in  1  enqueue request; enqReady_o  out  1  queue can accept.
REQ-005 enqIsWb_i  in  1; enqWbAddress_i  in  5; enqOpCode_i  in  7; enqPOperand_i  in  16; enqSOperand_i  in  16; these are the op fields.
REQ-006 loadStoreA_o  out  1; isWbA_o  out  1; wbAddressA_o  out  5; opCodeA_o  out  7; pOperandA_o  out  16; sOperandA_o  out  16; these drive data-cache port A.
REQ-007 Port B has the same six outputs with the B suffix, driving data-cache port B.
REQ-008 wbEnableA_i, wbEnableB_i  in  1 each; wbAddressA_i, wbAddressB_i  in  5 each; these are the data-cache writeback returns.
REQ-009 busy_o  out  32  pending-destination scoreboard; empty_o  out  1  queue empty.

Function
REQ-010 SHALL hold ops in an in-order FIFO of DEPTH entries; each entry holds {isWb, wbAddress, opCode, pOperand, sOperand}.
REQ-011 enqReady_o SHALL be (count < DEPTH), using the registered count only (no same-cycle dispatch bypass); an op is written when enqValid_i && enqReady_o.
REQ-012 Enqueue when not ready SHALL be ignored, with no state change.
REQ-013 Each cycle the block SHALL try to dispatch the head entry to port A, then head+1 to port B; B is dispatched only if A is also dispatched that cycle (strict order).
REQ-014 Dispatch outputs SHALL be registered, with loadStore*_o high for exactly one cycle per op; an undispatched port drives all its fields 0.
REQ-015 An entry written at edge N SHALL be eligible no earlier than edge N+1, so enqueue-to-loadStoreA_o latency is at least 2 cycles.
REQ-016 Cross-port memory hazard: if head and head+1 both have opcode 11 or 12 with equal sOperand and at least one is 12, only A SHALL dispatch that cycle.
REQ-017 Opcode 0 and undefined opcodes SHALL dispatch unchanged and never touch the scoreboard.
REQ-018 A dispatched op with isWb=1 and opcode 10 or 11 SHALL set busy_o[wbAddress] at the dispatch edge.
REQ-019 wbEnableA_i / wbEnableB_i high SHALL clear busy_o[wbAddress*_i] at that edge; a clear of a bit that is already 0 has no effect.
REQ-020 On a simultaneous set and clear of the same bit, set SHALL win; if both return ports name the same address, that bit SHALL clear once.
REQ-021 WAW stall: an op whose write-destination bit is busy SHALL NOT dispatch. If the head is stalled, nothing dispatches; if head+1 is stalled, only A dispatches.
REQ-022 If head and head+1 write the same destination, only A SHALL dispatch.
REQ-023 Simultaneous enqueue and dispatch SHALL update count by (+1 - dispatched). Pointers wrap modulo DEPTH.
REQ-024 empty_o SHALL be (count == 0); when the queue is empty, both ports drive idle (all fields 0).

Reset
REQ-025 While nReset_i=0: count, pointers, busy_o and all port outputs SHALL be 0; empty_o=1; enqReady_o=1.
REQ-026 Reset mid-operation SHALL drop all queued and in-flight ops; writebacks returning after reset only clear bits that are already 0.

Configuration
REQ-027 With LSU_SCOREBOARD_EN defined: REQ-018..REQ-022 apply.
REQ-028 Without LSU_SCOREBOARD_EN: busy_o is tied 0, the WAW stall is removed and REQ-022 is removed; REQ-016 still applies.

Verification
REQ-029 Reset, then enqueue op 10 {isWb=1, wbAddr=3, sOp=0x1234} -> loadStoreA_o=1 two cycles later, sOperandA_o=0x1234, busy_o[3]=1; wbEnableA_i=1 with wbAddressA_i=3 -> busy_o[3]=0 next cycle.
REQ-030 Enqueue store {op 12, sOp=0x40} then load {op 11, sOp=0x40} -> same cycle only A carries the store; the load goes out on A the next cycle.
REQ-031 Enqueue two ops with isWb=1 to wbAddr=5 (op 11, then op 10) -> second is held until wbAddressA_i=5 returns, then dispatches; with the macro undefined, both dispatch in one cycle on A/B.
REQ-032 Fill DEPTH=8 with the head stalled -> enqReady_o=0 at count 8 and a 9th enqValid_i is dropped; release the stall -> order of A/B outputs matches enqueue order, with wrap verified.
REQ-033 Assert nReset_i=0 with 5 entries queued and busy_o=0x28 -> all outputs 0 and empty_o=1 immediately (async); a late wbEnableB_i is harmless.
REQ-034 Same cycle: dispatch sets busy_o[7] while wbEnableA_i clears address 7 -> busy_o[7]=1.

Source files
------------

// File: rtl/lsu_dispatch_if.sv
// lsu_dispatch_if: enqueue handshake, dual data-cache dispatch ports, writeback returns and
// status of lsu_dispatch. The slave modport is the dispatcher; master is the surrounding pipeline.
interface lsu_dispatch_if;
  logic        enqValid_i;
  logic        enqReady_o;
  logic        enqIsWb_i;
  logic [4:0]  enqWbAddress_i;
  logic [6:0]  enqOpCode_i;
  logic [15:0] enqPOperand_i;
  logic [15:0] enqSOperand_i;

  logic        loadStoreA_o;
  logic        isWbA_o;
  logic [4:0]  wbAddressA_o;
  logic [6:0]  opCodeA_o;
  logic [15:0] pOperandA_o;
  logic [15:0] sOperandA_o;

  logic        loadStoreB_o;
  logic        isWbB_o;
  logic [4:0]  wbAddressB_o;
  logic [6:0]  opCodeB_o;
  logic [15:0] pOperandB_o;
  logic [15:0] sOperandB_o;

  logic        wbEnableA_i;
  logic        wbEnableB_i;
  logic [4:0]  wbAddressA_i;
  logic [4:0]  wbAddressB_i;

  logic [31:0] busy_o;
  logic        empty_o;

  modport slave (
    input  enqValid_i, enqIsWb_i, enqWbAddress_i, enqOpCode_i, enqPOperand_i, enqSOperand_i,
    input  wbEnableA_i, wbEnableB_i, wbAddressA_i, wbAddressB_i,
    output enqReady_o,
    output loadStoreA_o, isWbA_o, wbAddressA_o, opCodeA_o, pOperandA_o, sOperandA_o,
    output loadStoreB_o, isWbB_o, wbAddressB_o, opCodeB_o, pOperandB_o, sOperandB_o,
    output busy_o, empty_o
  );

  modport master (
    output enqValid_i, enqIsWb_i, enqWbAddress_i, enqOpCode_i, enqPOperand_i, enqSOperand_i,
    output wbEnableA_i, wbEnableB_i, wbAddressA_i, wbAddressB_i,
    input  enqReady_o,
    input  loadStoreA_o, isWbA_o, wbAddressA_o, opCodeA_o, pOperandA_o, sOperandA_o,
    input  loadStoreB_o, isWbB_o, wbAddressB_o, opCodeB_o, pOperandB_o, sOperandB_o,
    input  busy_o, empty_o
  );
endinterface

// File: rtl/lsu_dispatch.sv
// lsu_dispatch: in-order op queue issuing up to two ops per cycle to data-cache ports A and B.
// Define LSU_SCOREBOARD_EN to enable the busy_o destination scoreboard and WAW stalls.
module lsu_dispatch #(
  parameter int DEPTH = 8
) (
  input logic           clock_i,
  input logic           nReset_i,
  lsu_dispatch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic        isWb;
    logic [4:0]  wbAddress;
    logic [6:0]  opCode;
    logic [15:0] pOperand;
    logic [15:0] sOperand;
  } op_t;

  function automatic logic isMemOp(input logic [6:0] opCode);
    return (opCode == 7'd11) || (opCode == 7'd12);
  endfunction

  function automatic logic writesDest(input op_t e);
    return e.isWb && ((e.opCode == 7'd10) || (e.opCode == 7'd11));
  endfunction

  op_t           mem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  op_t           headOp, nextOp, portA, portB;
  logic          lsA, lsB;
  logic          enqFire, dispA, dispB, memHazard;
  logic          headStall, nextStall, sameDest;
  logic [1:0]    dispN;

  assign bus.enqReady_o = (count < DEPTH_C);
  assign bus.empty_o    = (count == '0);
  assign enqFire        = bus.enqValid_i && bus.enqReady_o;

  assign headOp = mem[rdPtr];
  assign nextOp = mem[rdPtr + PW'(1)];

  // A store paired with a load/store to the same address must not race it across ports.
  assign memHazard = isMemOp(headOp.opCode) && isMemOp(nextOp.opCode) &&
                     (headOp.sOperand == nextOp.sOperand) &&
                     ((headOp.opCode == 7'd12) || (nextOp.opCode == 7'd12));

  assign dispA = (count != '0) && !headStall;
  assign dispB = dispA && (count > CW'(1)) && !nextStall && !memHazard && !sameDest;
  assign dispN = {1'b0, dispA} + {1'b0, dispB};

`ifdef LSU_SCOREBOARD_EN
  logic [31:0] busy, setMask, clrMask;

  assign headStall = writesDest(headOp) && busy[headOp.wbAddress];
  assign nextStall = writesDest(nextOp) && busy[nextOp.wbAddress];
  assign sameDest  = writesDest(headOp) && writesDest(nextOp) &&
                     (headOp.wbAddress == nextOp.wbAddress);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (dispA && writesDest(headOp)) setMask[headOp.wbAddress] = 1'b1;
    if (dispB && writesDest(nextOp)) setMask[nextOp.wbAddress] = 1'b1;
    if (bus.wbEnableA_i) clrMask[bus.wbAddressA_i] = 1'b1;
    if (bus.wbEnableB_i) clrMask[bus.wbAddressB_i] = 1'b1;
  end

  // Set is applied after clear so a same-edge set of a returning address wins.
  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) busy <= '0;
    else           busy <= (busy & ~clrMask) | setMask;
  end

  assign bus.busy_o = busy;
`else
  logic unusedWbReturn;

  assign headStall      = 1'b0;
  assign nextStall      = 1'b0;
  assign sameDest       = 1'b0;
  assign bus.busy_o     = '0;
  assign unusedWbReturn = ^{bus.wbEnableA_i, bus.wbEnableB_i, bus.wbAddressA_i, bus.wbAddressB_i};
`endif

  // NOTE: queue storage is deliberately not reset; count and pointers decide which entries are live.
  always_ff @(posedge clock_i) begin
    if (enqFire) begin
      mem[wrPtr] <= {bus.enqIsWb_i, bus.enqWbAddress_i, bus.enqOpCode_i,
                     bus.enqPOperand_i, bus.enqSOperand_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock_i or negedge nReset_i) begin
    if (!nReset_i) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      lsA   <= 1'b0;
      lsB   <= 1'b0;
      portA <= '0;
      portB <= '0;
    end else begin
      count <= count + CW'(enqFire) - CW'(dispN);
      rdPtr <= rdPtr + PW'(dispN);
      if (enqFire) wrPtr <= wrPtr + PW'(1);
      lsA   <= dispA;
      lsB   <= dispB;
      portA <= dispA ? headOp : '0;
      portB <= dispB ? nextOp : '0;
    end
  end

  assign bus.loadStoreA_o = lsA;
  assign bus.isWbA_o      = portA.isWb;
  assign bus.wbAddressA_o = portA.wbAddress;
  assign bus.opCodeA_o    = portA.opCode;
  assign bus.pOperandA_o  = portA.pOperand;
  assign bus.sOperandA_o  = portA.sOperand;

  assign bus.loadStoreB_o = lsB;
  assign bus.isWbB_o      = portB.isWb;
  assign bus.wbAddressB_o = portB.wbAddress;
  assign bus.opCodeB_o    = portB.opCode;
  assign bus.pOperandB_o  = portB.pOperand;
  assign bus.sOperandB_o  = portB.sOperand;
endmodule

// File: tb/tb_lsu_dispatch.sv
// tb_lsu_dispatch: table vectors, directed corner sequences and random traffic for lsu_dispatch,
// checked against a queue-based model that follows LSU_SCOREBOARD_EN like the design does.
module tb_lsu_dispatch;
  localparam int DEPTH = 8;
`ifdef LSU_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct packed {
    logic        isWb;
    logic [4:0]  wbAddress;
    logic [6:0]  opCode;
    logic [15:0] pOperand;
    logic [15:0] sOperand;
  } entry_t;

  typedef struct packed {
    logic   ls;
    entry_t e;
  } port_t;

  typedef struct {
    logic        enq;
    logic [6:0]  op;
    logic [15:0] pOp;
    logic [15:0] sOp;
    logic        expLs;
    logic [6:0]  expOp;
    logic [15:0] expP;
    logic [15:0] expS;
    logic        expEmpty;
  } vec_t;

  logic   clk = 1'b0;
  logic   rstN;
  int     total = 0;
  int     bad = 0;
  entry_t opQ[$];
  logic [31:0] busyM;
  port_t  expA, expB;
  vec_t   vecs[8];

  lsu_dispatch_if bus();

  lsu_dispatch #(.DEPTH(DEPTH)) dut (
    .clock_i (clk),
    .nReset_i(rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [6:0] op,
                       input logic [15:0] p, input logic [15:0] s);
    bus.enqValid_i     = v;
    bus.enqIsWb_i      = w;
    bus.enqWbAddress_i = a;
    bus.enqOpCode_i    = op;
    bus.enqPOperand_i  = p;
    bus.enqSOperand_i  = s;
  endtask

  task automatic driveWb(input logic ea, input logic [4:0] aa, input logic eb, input logic [4:0] ab);
    bus.wbEnableA_i  = ea;
    bus.wbAddressA_i = aa;
    bus.wbEnableB_i  = eb;
    bus.wbAddressB_i = ab;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 7'd0, 16'd0, 16'd0);
    driveWb(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Reference model: the queue holds pending ops in program order; busyM is the set of
  // destinations with an outstanding writeback.
  function automatic bit writes(input entry_t e);
    return e.isWb && (e.opCode == 7'd10 || e.opCode == 7'd11);
  endfunction

  function automatic bit blocked(input entry_t e);
    return SB && writes(e) && busyM[e.wbAddress];
  endfunction

  function automatic bit pairConflict(input entry_t h, input entry_t n);
    bit memPair, destPair;
    memPair  = (h.opCode == 7'd11 || h.opCode == 7'd12) && (n.opCode == 7'd11 || n.opCode == 7'd12)
               && (h.sOperand == n.sOperand) && (h.opCode == 7'd12 || n.opCode == 7'd12);
    destPair = SB && writes(h) && writes(n) && (h.wbAddress == n.wbAddress);
    return memPair || destPair;
  endfunction

  task automatic modelReset();
    opQ.delete();
    busyM = '0;
    expA  = '0;
    expB  = '0;
  endtask

  task automatic modelEdge();
    int          sz;
    bit          goA, goB;
    logic [31:0] setM, clrM;
    entry_t      inE;
    sz   = opQ.size();
    goA  = (sz >= 1) && !blocked(opQ[0]);
    goB  = goA && (sz >= 2) && !blocked(opQ[1]) && !pairConflict(opQ[0], opQ[1]);
    expA = '0;
    expB = '0;
    setM = '0;
    clrM = '0;
    if (goA) begin expA.ls = 1'b1; expA.e = opQ[0]; if (writes(opQ[0])) setM[opQ[0].wbAddress] = 1'b1; end
    if (goB) begin expB.ls = 1'b1; expB.e = opQ[1]; if (writes(opQ[1])) setM[opQ[1].wbAddress] = 1'b1; end
    if (bus.wbEnableA_i) clrM[bus.wbAddressA_i] = 1'b1;
    if (bus.wbEnableB_i) clrM[bus.wbAddressB_i] = 1'b1;
    if (SB) busyM = (busyM & ~clrM) | setM;
    inE = {bus.enqIsWb_i, bus.enqWbAddress_i, bus.enqOpCode_i, bus.enqPOperand_i, bus.enqSOperand_i};
    if (goA) void'(opQ.pop_front());
    if (goB) void'(opQ.pop_front());
    if (bus.enqValid_i && sz < DEPTH) opQ.push_back(inE);
  endtask

  task automatic compareAll();
    port_t a, b;
    a = {bus.loadStoreA_o, bus.isWbA_o, bus.wbAddressA_o, bus.opCodeA_o, bus.pOperandA_o, bus.sOperandA_o};
    b = {bus.loadStoreB_o, bus.isWbB_o, bus.wbAddressB_o, bus.opCodeB_o, bus.pOperandB_o, bus.sOperandB_o};
    check("portA", a, expA);
    check("portB", b, expB);
    check("busy", bus.busy_o, busyM);
    check("ready_empty", {bus.enqReady_o, bus.empty_o}, {1'(opQ.size() < DEPTH), 1'(opQ.size() == 0)});
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    #1;
    modelReset();
    compareAll();
    check("reset_outputs", {bus.busy_o, bus.loadStoreA_o, bus.loadStoreB_o, bus.sOperandA_o,
                            bus.empty_o, bus.enqReady_o}, {32'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 7'd12, 16'h0011, 16'h0040, 1'b0, 7'd0,  16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 7'd11, 16'h0022, 16'h0040, 1'b1, 7'd12, 16'h0011, 16'h0040, 1'b0};
    vecs[2] = '{1'b0, 7'd0,  16'h0000, 16'h0000, 1'b1, 7'd11, 16'h0022, 16'h0040, 1'b1};
    vecs[3] = '{1'b0, 7'd0,  16'h0000, 16'h0000, 1'b0, 7'd0,  16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 7'd0,  16'h0033, 16'hBEEF, 1'b0, 7'd0,  16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 7'd99, 16'h0044, 16'h0007, 1'b1, 7'd0,  16'h0033, 16'hBEEF, 1'b0};
    vecs[6] = '{1'b0, 7'd0,  16'h0000, 16'h0000, 1'b1, 7'd99, 16'h0044, 16'h0007, 1'b1};
    vecs[7] = '{1'b0, 7'd0,  16'h0000, 16'h0000, 1'b0, 7'd0,  16'h0000, 16'h0000, 1'b1};

    rstN = 1'b1;
    idle();
    #2;
    applyReset();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].enq, 1'b0, 5'd0, vecs[i].op, vecs[i].pOp, vecs[i].sOp);
      tick();
      check($sformatf("vec%0d", i),
            {bus.loadStoreA_o, bus.opCodeA_o, bus.pOperandA_o, bus.sOperandA_o, bus.loadStoreB_o, bus.empty_o},
            {vecs[i].expLs, vecs[i].expOp, vecs[i].expP, vecs[i].expS, 1'b0, vecs[i].expEmpty});
    end

    // Writeback op goes out two cycles after it is presented and marks its destination busy.
    applyReset();
    drive(1'b1, 1'b1, 5'd3, 7'd10, 16'h0000, 16'h1234);
    tick();
    idle();
    tick();
    check("wb_issue", {bus.loadStoreA_o, bus.sOperandA_o, bus.busy_o[3]}, {1'b1, 16'h1234, SB});
    driveWb(1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    idle();
    check("wb_clear", bus.busy_o[3], 1'b0);

    // Same-destination pair: the second op waits for the first writeback when the scoreboard is on.
    applyReset();
    drive(1'b1, 1'b1, 5'd5, 7'd11, 16'h0000, 16'h0001);
    tick();
    drive(1'b1, 1'b1, 5'd5, 7'd10, 16'h0000, 16'h0002);
    tick();
    check("waw_first", {bus.loadStoreA_o, bus.opCodeA_o}, {1'b1, 7'd11});
    idle();
    tick();
    check("waw_second_early", {bus.loadStoreA_o, bus.opCodeA_o}, SB ? {1'b0, 7'd0} : {1'b1, 7'd10});
    repeat (3) tick();
    driveWb(1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    idle();
    tick();
    check("waw_second_late", {bus.loadStoreA_o, bus.opCodeA_o}, SB ? {1'b1, 7'd10} : {1'b0, 7'd0});
    repeat (2) tick();

    // Fill behind a stalled head, drop the overflow op, then drain across the pointer wrap.
    applyReset();
    drive(1'b1, 1'b1, 5'd1, 7'd10, 16'h0000, 16'h0000); tick();
    drive(1'b1, 1'b1, 5'd1, 7'd10, 16'h0000, 16'h0001); tick();
    drive(1'b1, 1'b0, 5'd0, 7'd0,  16'h0001, 16'h0002); tick();
    drive(1'b1, 1'b0, 5'd0, 7'd12, 16'h0000, 16'h0040); tick();
    drive(1'b1, 1'b0, 5'd0, 7'd11, 16'h0000, 16'h0040); tick();
    drive(1'b1, 1'b0, 5'd0, 7'd0,  16'h0002, 16'h0003); tick();
    drive(1'b1, 1'b1, 5'd6, 7'd11, 16'h0000, 16'h0005); tick();
    drive(1'b1, 1'b1, 5'd6, 7'd10, 16'h0000, 16'h0006); tick();
    drive(1'b1, 1'b0, 5'd0, 7'd0,  16'h0003, 16'h0004); tick();
    check("full_ready", bus.enqReady_o, !SB);
    drive(1'b1, 1'b0, 5'd0, 7'd0,  16'h0009, 16'h0009); tick();
    idle();
    driveWb(1'b1, 5'd1, 1'b0, 5'd0);
    tick();
    idle();
    repeat (8) tick();
    driveWb(1'b0, 5'd0, 1'b1, 5'd6);
    tick();
    idle();
    repeat (4) tick();
    check("drained_empty", bus.empty_o, 1'b1);

    // Asynchronous reset with ops queued and destinations busy; a late return must be harmless.
    applyReset();
    drive(1'b1, 1'b1, 5'd3, 7'd10, 16'h0000, 16'h0010); tick();
    drive(1'b1, 1'b1, 5'd5, 7'd10, 16'h0000, 16'h0011); tick();
    drive(1'b1, 1'b1, 5'd3, 7'd10, 16'h0000, 16'h0012); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 5'd0, 7'd0, 16'(i), 16'(i + 32));
      tick();
    end
    idle();
    tick();
    check("pre_reset_busy", {bus.busy_o, bus.empty_o}, SB ? {32'h28, 1'b0} : {32'h0, 1'b1});
    #3;
    applyReset();
    driveWb(1'b0, 5'd0, 1'b1, 5'd5);
    tick();
    idle();
    check("late_wb_busy", bus.busy_o, 32'd0);

    // Set and clear of the same destination on one edge: the set wins; a double clear is a single clear.
    applyReset();
    drive(1'b1, 1'b1, 5'd7, 7'd10, 16'h0000, 16'h0077);
    tick();
    idle();
    driveWb(1'b1, 5'd7, 1'b0, 5'd0);
    tick();
    check("set_beats_clear", {bus.loadStoreA_o, bus.busy_o[7]}, {1'b1, SB});
    driveWb(1'b1, 5'd7, 1'b1, 5'd7);
    tick();
    idle();
    check("double_clear", bus.busy_o, 32'd0);

    applyReset();
    for (int c = 0; c < 600; c++) begin
      int          sel;
      logic [6:0]  op;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       op = 7'd0;
        1:       op = 7'd10;
        2:       op = 7'd11;
        3:       op = 7'd12;
        default: op = 7'($urandom_range(13, 127));
      endcase
      drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), op,
            16'($urandom), 16'($urandom_range(0, 3)));
      driveWb($urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)));
      tick();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
